// File: rtl/vga_sync_decoder_if.sv
// Sync inputs and decoded raster outputs of vga_sync_decoder.
// Plain wiring, no latency; pix_en is the only qualifier and there is no backpressure.
interface vga_sync_decoder_if #(
   parameter int bitDim = 11
);
   logic              pix_en;
   logic              hsync_n;
   logic              vsync_n;
   logic [bitDim-1:0] x;
   logic [bitDim-1:0] y;
   logic              active;
   logic [bitDim-1:0] line_len;
   logic [bitDim-1:0] frame_lines;
   logic              locked;
   logic              err;

   modport master (
      output pix_en, hsync_n, vsync_n,
      input  x, y, active, line_len, frame_lines, locked, err
   );

   modport slave (
      input  pix_en, hsync_n, vsync_n,
      output x, y, active, line_len, frame_lines, locked, err
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers raster position from VGA syncs, measures line/frame periods and locks to the nominal timing.
// Outputs registered one clk after each pix_en sample and held while pix_en is low; no backpressure.
module vga_sync_decoder #(
   parameter int bitDim   = 11,
   parameter int H_TOTAL  = 800,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int H_ACTIVE = 640,
   parameter int V_TOTAL  = 525,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int V_ACTIVE = 480
) (
   input  logic              clk,
   input  logic              rst_n,
   vga_sync_decoder_if.slave sync_if
);

   localparam logic [bitDim-1:0] CNT_MAX   = {bitDim{1'b1}};
   localparam logic [bitDim-1:0] ONE       = bitDim'(1);
   localparam logic [bitDim-1:0] H_TOTAL_W = bitDim'(H_TOTAL);
   localparam logic [bitDim-1:0] V_TOTAL_W = bitDim'(V_TOTAL);
   localparam logic [bitDim-1:0] H_START_W = bitDim'(H_SYNC + H_BP);
   localparam logic [bitDim-1:0] H_END_W   = bitDim'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [bitDim-1:0] V_START_W = bitDim'(V_SYNC + V_BP);
   localparam logic [bitDim-1:0] V_END_W   = bitDim'(V_SYNC + V_BP + V_ACTIVE);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } lock_state_t;

   logic              hs_q, hs_d;
   logic              vs_q, vs_d;
   logic [bitDim-1:0] h_cnt_q, h_cnt_d;
   logic [bitDim-1:0] v_cnt_q, v_cnt_d;
   logic              pend_q, pend_d;
   logic [bitDim-1:0] line_len_q, line_len_d;
   logic [bitDim-1:0] frame_lines_q, frame_lines_d;
   logic [bitDim-1:0] x_q, x_d;
   logic [bitDim-1:0] y_q, y_d;
   logic              active_q, active_d;
   lock_state_t       state_q;
   logic              locked_q;
   logic              err_q;

   logic              h_edge;
   logic              v_edge;
   logic              frame_end;
   logic              h_sat;
   logic              v_sat;
   logic              h_sat_now;
   logic              in_view;
   logic              line_bad;
   logic              frame_bad;
   logic [bitDim-1:0] line_len_nx;
   logic [bitDim-1:0] frame_lines_nx;

   // Edges compare the stored sample against the sample being taken this cycle.
   assign h_edge    = sync_if.pix_en && hs_q && !sync_if.hsync_n;
   assign v_edge    = sync_if.pix_en && vs_q && !sync_if.vsync_n;
   assign frame_end = h_edge && (pend_q || v_edge);

   assign h_sat     = (h_cnt_q == CNT_MAX);
   assign v_sat     = (v_cnt_q == CNT_MAX);
   assign h_sat_now = sync_if.pix_en && !h_edge && (h_cnt_q == CNT_MAX - ONE);

   assign line_len_nx    = h_sat ? CNT_MAX : h_cnt_q + ONE;
   assign frame_lines_nx = v_sat ? CNT_MAX : v_cnt_q + ONE;
   assign line_bad       = h_edge && (line_len_nx != H_TOTAL_W);
   assign frame_bad      = frame_end && (frame_lines_nx != V_TOTAL_W);

   assign in_view = (h_cnt_q >= H_START_W) && (h_cnt_q < H_END_W) &&
                    (v_cnt_q >= V_START_W) && (v_cnt_q < V_END_W);

   always_comb begin
      hs_d          = hs_q;
      vs_d          = vs_q;
      h_cnt_d       = h_cnt_q;
      v_cnt_d       = v_cnt_q;
      pend_d        = pend_q;
      line_len_d    = line_len_q;
      frame_lines_d = frame_lines_q;
      active_d      = active_q;
      x_d           = x_q;
      y_d           = y_q;
      if (sync_if.pix_en) begin
         hs_d     = sync_if.hsync_n;
         vs_d     = sync_if.vsync_n;
         active_d = in_view;
         x_d      = in_view ? h_cnt_q - H_START_W : '0;
         y_d      = in_view ? v_cnt_q - V_START_W : '0;
         if (h_edge) begin
            h_cnt_d    = '0;
            line_len_d = line_len_nx;
            // A vsync seen earlier (or right now) closes the frame on this line start.
            if (frame_end) begin
               frame_lines_d = frame_lines_nx;
               v_cnt_d       = '0;
               pend_d        = 1'b0;
            end else begin
               v_cnt_d = v_sat ? v_cnt_q : v_cnt_q + ONE;
            end
         end else begin
            h_cnt_d = h_sat ? h_cnt_q : h_cnt_q + ONE;
            if (v_edge) begin
               pend_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q          <= 1'b1;
         vs_q          <= 1'b1;
         h_cnt_q       <= '0;
         v_cnt_q       <= '0;
         pend_q        <= 1'b0;
         line_len_q    <= '0;
         frame_lines_q <= '0;
         active_q      <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
      end else begin
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         h_cnt_q       <= h_cnt_d;
         v_cnt_q       <= v_cnt_d;
         pend_q        <= pend_d;
         line_len_q    <= line_len_d;
         frame_lines_q <= frame_lines_d;
         active_q      <= active_d;
         x_q           <= x_d;
         y_q           <= y_d;
      end
   end

   // Lock tracker: err only ever leaves CHECK or LOCKED, so SEARCH stays silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SEARCH;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= 1'b0;
         if (sync_if.pix_en) begin
            case (state_q)
               SEARCH: begin
                  if (frame_end) begin
                     state_q <= CHECK;
                  end
               end
               CHECK: begin
                  if (line_bad || h_sat_now || frame_bad) begin
                     state_q <= SEARCH;
                     err_q   <= 1'b1;
                  end else if (frame_end) begin
                     state_q  <= LOCKED;
                     locked_q <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (line_bad || h_sat_now || frame_bad) begin
                     state_q  <= SEARCH;
                     locked_q <= 1'b0;
                     err_q    <= 1'b1;
                  end
               end
               default: begin
                  state_q  <= SEARCH;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sync_if.x           = x_q;
   assign sync_if.y           = y_q;
   assign sync_if.active      = active_q;
   assign sync_if.line_len    = line_len_q;
   assign sync_if.frame_lines = frame_lines_q;
   assign sync_if.locked      = locked_q;
   assign sync_if.err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster so whole frames stay short.
module tb_vga_sync_decoder;

   localparam int BD   = 6;
   localparam int HT   = 20;
   localparam int HS   = 2;
   localparam int HB   = 3;
   localparam int HA   = 12;
   localparam int VT   = 12;
   localparam int VS   = 2;
   localparam int VB   = 2;
   localparam int VA   = 6;
   localparam int CMAX = 63;
   localparam int HOLD = 70;

   typedef struct {
      logic act;
      int   x;
      int   y;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   vga_sync_decoder_if #(.bitDim(BD)) bus ();

   vga_sync_decoder #(
      .bitDim(BD), .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
      .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sync_if (bus)
   );

   exp_t sb[$];
   exp_t last_exp;
   int   n_chk = 0;
   int   n_fail = 0;
   int   err_seen = 0;
   int   mh, mv;
   logic ms_h, ms_v;
   bit   sat_now;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      mh = 0;
      mv = 0;
      ms_h = 1'b1;
      ms_v = 1'b1;
      sb.delete();
      last_exp = '{act: 1'b0, x: 0, y: 0};
   endtask

   // Raster model: position counted since the last hsync/vsync leading edge; outputs trail by one sample.
   task automatic step(input logic hs, input logic vs, input logic pe);
      exp_t e;
      bit   eh, ev;
      bus.hsync_n = hs;
      bus.vsync_n = vs;
      bus.pix_en  = pe;
      sat_now = 1'b0;
      if (pe) begin
         eh = ms_h && !hs;
         ev = ms_v && !vs;
         e.act = (mh >= HS+HB) && (mh < HS+HB+HA) && (mv >= VS+VB) && (mv < VS+VB+VA);
         e.x = e.act ? mh - (HS+HB) : 0;
         e.y = e.act ? mv - (VS+VB) : 0;
         if (eh) begin
            mh = 0;
            mv = ev ? 0 : ((mv < CMAX) ? mv + 1 : CMAX);
         end else if (mh < CMAX) begin
            mh++;
            sat_now = (mh == CMAX);
         end
         ms_h = hs;
         ms_v = vs;
         last_exp = e;
      end
      sb.push_back(last_exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("active", bus.active, e.act);
      chk("x", bus.x, e.x);
      chk("y", bus.y, e.y);
      if (bus.err === 1'b1) err_seen++;
   endtask

   task automatic run_frame(input int l0, input int l1, input int short_line,
                            input int hold_line, input bit tog);
      int   len;
      logic hs, vs;
      for (int l = l0; l < l1; l++) begin
         len = (l == short_line) ? HT - 1 : ((l == hold_line) ? HOLD : HT);
         for (int p = 0; p < len; p++) begin
            hs = (l == hold_line) ? 1'b1 : ((p < HS) ? 1'b0 : 1'b1);
            vs = (l < VS) ? 1'b0 : 1'b1;
            step(hs, vs, 1'b1);
            if (short_line >= 0 && l == short_line + 1 && p == 0) begin
               chk("err_short_line", bus.err, 1);
               chk("line_len_short", bus.line_len, HT - 1);
               chk("locked_after_short", bus.locked, 0);
            end
            if (short_line >= 0 && l == short_line + 1 && p == 1)
               chk("err_one_cycle", bus.err, 0);
            if (l == hold_line && sat_now) begin
               chk("err_on_sat", bus.err, 1);
               chk("locked_after_sat", bus.locked, 0);
            end
            if (hold_line >= 0 && l == hold_line + 1 && p == 0)
               chk("line_len_sat", bus.line_len, CMAX);
            if (tog) step(hs, vs, 1'b0);
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_x"}, bus.x, 0);
      chk({tag, "_y"}, bus.y, 0);
      chk({tag, "_active"}, bus.active, 0);
      chk({tag, "_line_len"}, bus.line_len, 0);
      chk({tag, "_frame_lines"}, bus.frame_lines, 0);
      chk({tag, "_locked"}, bus.locked, 0);
      chk({tag, "_err"}, bus.err, 0);
   endtask

   initial begin
      bus.pix_en  = 1'b0;
      bus.hsync_n = 1'b1;
      bus.vsync_n = 1'b1;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Three clean frames with pix_en held high
      err_seen = 0;
      run_frame(0, VT, -1, -1, 1'b0);
      chk("locked_f1", bus.locked, 0);
      run_frame(0, VT, -1, -1, 1'b0);
      chk("locked_f2", bus.locked, 1);
      chk("line_len_f2", bus.line_len, HT);
      chk("frame_lines_f2", bus.frame_lines, VT);
      run_frame(0, VT, -1, -1, 1'b0);
      chk("locked_f3", bus.locked, 1);
      chk("err_count_clean", err_seen, 0);

      // One short line while locked
      err_seen = 0;
      run_frame(0, VT, 7, -1, 1'b0);
      chk("err_count_short", err_seen, 1);
      run_frame(0, VT, -1, -1, 1'b0);
      chk("locked_short_c1", bus.locked, 0);
      run_frame(0, VT, -1, -1, 1'b0);
      chk("locked_short_c2", bus.locked, 1);
      chk("err_count_relock", err_seen, 1);

      // hsync stuck high while locked
      err_seen = 0;
      run_frame(0, VT, -1, 5, 1'b0);
      chk("err_count_sat", err_seen, 1);
      chk("locked_sat", bus.locked, 0);
      run_frame(0, VT, -1, -1, 1'b0);
      run_frame(0, VT, -1, -1, 1'b0);
      chk("locked_sat_relock", bus.locked, 1);
      chk("line_len_sat_relock", bus.line_len, HT);

      // Mid-frame reset, taken while a visible pixel is showing
      run_frame(0, 5, -1, -1, 1'b0);
      for (int p = 0; p < 8; p++) step((p < HS) ? 1'b0 : 1'b1, 1'b1, 1'b1);
      chk("active_before_rst", bus.active, 1);
      chk("x_before_rst", bus.x, 1);
      chk("locked_before_rst", bus.locked, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      // Rest of the frame then three frames with pix_en toggling
      err_seen = 0;
      run_frame(6, VT, -1, -1, 1'b1);
      chk("locked_partial", bus.locked, 0);
      run_frame(0, VT, -1, -1, 1'b1);
      chk("locked_t1", bus.locked, 0);
      run_frame(0, VT, -1, -1, 1'b1);
      chk("locked_t2", bus.locked, 1);
      chk("line_len_t2", bus.line_len, HT);
      chk("frame_lines_t2", bus.frame_lines, VT);
      run_frame(0, VT, -1, -1, 1'b1);
      chk("locked_t3", bus.locked, 1);
      chk("err_count_toggle", err_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
